ovf_exc_ctrl: RTL and testbench
===============================

# ovf_exc_ctrl

Overflow exception controller for the multi-cycle MIPS CPU. It consumes the signed-overflow flag produced beside the ALU for add/sub operations, records the fault in a minimal CP0 (Status, Cause, EPC), suppresses the faulting write-back and redirects the PC to the exception vector through a request/acknowledge handshake with the main control FSM. It also services `eret` and `mtc0`/`mfc0` accesses to those three registers.

## Interface

**Parameters**

- `EXC_VECTOR`, default 32'h8000_0180: PC loaded on exception entry.
- `OV_CODE`, default 5'd12: ExcCode written to Cause[6:2] on overflow.

**Ports**

- `clk` input 1: clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `ovf_chk` input 1: control FSM is in the ALU cycle of a trapping add/sub; `ovf` is valid.
- `ovf` input 1: signed overflow flag for the current ALU result.
- `pc_cur` input 32: address of the instruction in the ALU cycle.
- `eret` input 1: one-cycle strobe, eret decoded.
- `cp0_we` input 1: mtc0 write strobe.
- `cp0_addr` input 5: CP0 register number; 12 = Status, 13 = Cause, 14 = EPC.
- `cp0_wdata` input 32: mtc0 data.
- `ctrl_ack` input 1: control FSM has accepted the exception request.
- `cp0_rdata` output 32: combinational read of `cp0_addr`; 0 for unmapped numbers.
- `exc_req` output 1: exception pending, held until acknowledged.
- `wb_kill` output 1: inhibit register-file write for the faulting instruction.
- `pc_load` output 1: one-cycle PC load strobe.
- `pc_next` output 32: PC value valid while `pc_load` = 1.
- `exl` output 1: Status.EXL.
- `ovf_cnt` output 8: saturating count of overflow exceptions taken.

## Operation

- **Registers**
  - Status: only bit 1 (EXL) and bit 0 (IE) are implemented. Other bits read 0.
  - Cause: only ExcCode[6:2] is implemented.
  - EPC: full 32 bits.
- **FSM states:** IDLE, TRAP, VECTOR, RET.
- **IDLE**
  - On `ovf_chk && ovf`, go to TRAP.
    - Cause.ExcCode ← `OV_CODE`.
    - If EXL = 0, EPC ← `pc_cur`. If EXL = 1 (nested), EPC is unchanged.
    - EXL ← 1.
    - `ovf_cnt` increments and saturates at 255.
  - Else on `eret`, go to RET.
  - `ovf_chk` with `ovf` = 0 has no effect.
- **TRAP**
  - `exc_req` = 1 and `wb_kill` = 1.
  - Stays in TRAP until `ctrl_ack` = 1, then goes to VECTOR.
- **VECTOR**
  - `wb_kill` = 1, `pc_load` = 1, `pc_next` = `EXC_VECTOR`.
  - Goes unconditionally to IDLE after one cycle.
- **RET**
  - `pc_load` = 1, `pc_next` = EPC, EXL ← 0.
  - Goes unconditionally to IDLE after one cycle.
- **Ignored inputs:** `ovf_chk`, `ovf` and `eret` are ignored outside IDLE.
- **Same-cycle priorities**
  - Overflow beats `eret` in IDLE.
  - An overflow capture beats an `mtc0` to the same register. An `mtc0` to other registers in that cycle still takes effect.
  - An `mtc0` to Status in the RET cycle loses to the EXL clear for bit 1 only.
- **mtc0:** writes only the implemented bits. Writes to unmapped numbers are dropped.
- **cp0_rdata:** reflects register state before any same-cycle write.

## Timing

- **Reset values** (asynchronous, whenever `rst_n` = 0):
  - state IDLE.
  - Status, Cause, EPC = 0; `ovf_cnt` = 0.
  - `exc_req`, `wb_kill`, `pc_load`, `exl` = 0; `pc_next` = 0; `cp0_rdata` = 0.
- **Reset mid-operation:** reset asserted in TRAP or VECTOR abandons the request with no PC load.
- **Exception entry latency**
  - The overflow is sampled at the rising edge that ends the `ovf_chk` cycle.
  - `exc_req` and `wb_kill` are high in the next cycle.
  - Minimum entry: ALU cycle N, TRAP N+1 with `ctrl_ack` = 1, VECTOR N+2 with `pc_load`. So `pc_load` comes 2 cycles after the ALU cycle.
- **Handshake:** `exc_req` stays high for as many cycles as `ctrl_ack` is low. `ctrl_ack` outside TRAP is ignored.
- **eret latency:** `eret` strobe in cycle N gives `pc_load` with EPC in N+1. `exl` reads 0 from N+2.
- **Outputs:** all outputs except `cp0_rdata` and `pc_next` are decoded from registered state only (Moore).

## Test plan

- **Reset:** assert `rst_n` = 0 mid-TRAP -> `exc_req`, `wb_kill`, `pc_load` drop immediately; `cp0_rdata` for addr 14 reads 0 after release.
- **Overflow entry:** `ovf_chk` = 1, `ovf` = 1, `pc_cur` = 0x0040_0010, `ctrl_ack` delayed 3 cycles ->
  - `exc_req` high for 3 cycles, `wb_kill` high through VECTOR.
  - `pc_load` with 0x8000_0180.
  - EPC = 0x0040_0010, Cause = 0x30, Status = 0x2, `ovf_cnt` = 1.
- **No overflow:** `ovf_chk` = 1, `ovf` = 0 -> no request; all CP0 values unchanged.
- **Return:** after entry, `eret` pulse -> next cycle `pc_load` with `pc_next` = 0x0040_0010; `exl` = 0 afterwards.
- **Nested overflow with EXL = 1:** second overflow at `pc_cur` = 0x8000_0184 -> EPC stays 0x0040_0010 and the vector is taken again. Same-cycle `ovf` + `eret` in IDLE -> exception taken, `eret` ignored.
- **mtc0 and saturation:**
  - `mtc0` EPC = 0x1234_5678, then `eret` -> `pc_next` = 0x1234_5678.
  - `mtc0` Status = 0xFFFF_FFFF -> reads 0x3.
  - 256 overflows -> `ovf_cnt` holds 255.

Source files
------------

// File: rtl/ovf_exc_ctrl.sv
// Overflow exception controller: minimal CP0 (Status/Cause/EPC), trap entry
// via req/ack with the main control FSM, eret return, mtc0/mfc0 access.
module ovf_exc_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'h8000_0180,
  parameter logic [4:0]  OV_CODE    = 5'd12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ovf_chk,
  input  logic        ovf,
  input  logic [31:0] pc_cur,
  input  logic        eret,
  input  logic        cp0_we,
  input  logic [4:0]  cp0_addr,
  input  logic [31:0] cp0_wdata,
  input  logic        ctrl_ack,
  output logic [31:0] cp0_rdata,
  output logic        exc_req,
  output logic        wb_kill,
  output logic        pc_load,
  output logic [31:0] pc_next,
  output logic        exl,
  output logic [7:0]  ovf_cnt
);

  localparam logic [4:0] A_STATUS = 5'd12;
  localparam logic [4:0] A_CAUSE  = 5'd13;
  localparam logic [4:0] A_EPC    = 5'd14;

  typedef enum logic [1:0] {IDLE, TRAP, VECTOR, RET} state_t;

  state_t      state;
  logic        ie;
  logic        exl_q;
  logic [4:0]  exc_code;
  logic [31:0] epc;

  logic cap, epc_cap;
  logic wr_sts, wr_cause, wr_epc;

  assign cap     = (state == IDLE) && ovf_chk && ovf;
  assign epc_cap = cap && !exl_q;

  // A capture owns any register it writes that cycle; nested traps leave EPC
  // alone, so an mtc0 to EPC then still lands.
  assign wr_sts   = cp0_we && (cp0_addr == A_STATUS) && !cap;
  assign wr_cause = cp0_we && (cp0_addr == A_CAUSE)  && !cap;
  assign wr_epc   = cp0_we && (cp0_addr == A_EPC)    && !epc_cap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      exc_req <= 1'b0;
      wb_kill <= 1'b0;
      pc_load <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cap) begin
            state   <= TRAP;
            exc_req <= 1'b1;
            wb_kill <= 1'b1;
          end else if (eret) begin
            state   <= RET;
            pc_load <= 1'b1;
          end
        end
        TRAP: begin
          if (ctrl_ack) begin
            state   <= VECTOR;
            exc_req <= 1'b0;
            pc_load <= 1'b1;
          end
        end
        VECTOR: begin
          state   <= IDLE;
          wb_kill <= 1'b0;
          pc_load <= 1'b0;
        end
        RET: begin
          state   <= IDLE;
          pc_load <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          exc_req <= 1'b0;
          wb_kill <= 1'b0;
          pc_load <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ie       <= 1'b0;
      exl_q    <= 1'b0;
      exc_code <= 5'd0;
      epc      <= 32'd0;
      ovf_cnt  <= 8'd0;
    end else begin
      if (wr_sts) begin
        ie    <= cp0_wdata[0];
        exl_q <= cp0_wdata[1];
      end
      if (wr_cause) exc_code <= cp0_wdata[6:2];
      if (wr_epc)   epc      <= cp0_wdata;
      if (cap) begin
        exl_q    <= 1'b1;
        exc_code <= OV_CODE;
        if (ovf_cnt != 8'hff) ovf_cnt <= ovf_cnt + 8'd1;
      end
      if (epc_cap) epc <= pc_cur;
      // eret clears EXL even against a same-cycle mtc0; IE still follows mtc0
      if (state == RET) exl_q <= 1'b0;
    end
  end

  assign exl = exl_q;

  always_comb begin
    case (state)
      VECTOR:  pc_next = EXC_VECTOR;
      RET:     pc_next = epc;
      default: pc_next = 32'd0;
    endcase
  end

  always_comb begin
    case (cp0_addr)
      A_STATUS: cp0_rdata = {30'd0, exl_q, ie};
      A_CAUSE:  cp0_rdata = {25'd0, exc_code, 2'b00};
      A_EPC:    cp0_rdata = epc;
      default:  cp0_rdata = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_ovf_exc_ctrl.sv
// Randomized + directed bench for ovf_exc_ctrl against a cycle-level
// behavioural model of the exception controller.
module tb_ovf_exc_ctrl;

  localparam logic [31:0] VEC = 32'h8000_0180;

  logic        gclk = 1'b0;
  logic        rst_n;
  logic        ovf_chk, ovf, eret, cp0_we, ctrl_ack;
  logic [31:0] pc_cur, cp0_wdata;
  logic [4:0]  cp0_addr;
  logic [31:0] cp0_rdata, pc_next;
  logic        exc_req, wb_kill, pc_load, exl;
  logic [7:0]  ovf_cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 gclk = ~gclk;

  ovf_exc_ctrl #(.EXC_VECTOR(VEC), .OV_CODE(5'd12)) dut (
    .clk(gclk), .rst_n(rst_n), .ovf_chk(ovf_chk), .ovf(ovf), .pc_cur(pc_cur),
    .eret(eret), .cp0_we(cp0_we), .cp0_addr(cp0_addr), .cp0_wdata(cp0_wdata),
    .ctrl_ack(ctrl_ack), .cp0_rdata(cp0_rdata), .exc_req(exc_req),
    .wb_kill(wb_kill), .pc_load(pc_load), .pc_next(pc_next), .exl(exl),
    .ovf_cnt(ovf_cnt)
  );

  // model: what the controller is doing this cycle, plus CP0 contents
  typedef enum {M_IDLE, M_WAIT_ACK, M_VECTOR, M_RETURN} mode_t;
  mode_t       m_mode;
  bit          m_ie, m_exl;
  int unsigned m_code, m_epc, m_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_ie = 0; m_exl = 0; m_code = 0; m_epc = 0; m_cnt = 0;
  endtask

  task automatic model_step();
    bit    trap;
    mode_t nm;
    trap = (m_mode == M_IDLE) && ovf_chk && ovf;
    nm   = M_IDLE;
    case (m_mode)
      M_IDLE:     nm = trap ? M_WAIT_ACK : (eret ? M_RETURN : M_IDLE);
      M_WAIT_ACK: nm = ctrl_ack ? M_VECTOR : M_WAIT_ACK;
      default:    nm = M_IDLE;
    endcase
    if (cp0_we && cp0_addr == 12 && !trap) begin
      m_ie  = cp0_wdata[0];
      m_exl = cp0_wdata[1];
    end
    if (cp0_we && cp0_addr == 13 && !trap) m_code = (cp0_wdata >> 2) & 32'h1f;
    if (cp0_we && cp0_addr == 14 && !(trap && !m_exl)) m_epc = cp0_wdata;
    if (trap) begin
      if (!m_exl) m_epc = pc_cur;
      m_exl  = 1;
      m_code = 12;
      if (m_cnt < 255) m_cnt++;
    end
    if (m_mode == M_RETURN) m_exl = 0;
    m_mode = nm;
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] a);
    case (a)
      5'd12:   return {30'd0, m_exl, m_ie};
      5'd13:   return m_code << 2;
      5'd14:   return m_epc;
      default: return 32'd0;
    endcase
  endfunction

  task automatic check_all();
    chk("exc_req", {31'd0, exc_req}, {31'd0, m_mode == M_WAIT_ACK});
    chk("wb_kill", {31'd0, wb_kill}, {31'd0, m_mode == M_WAIT_ACK || m_mode == M_VECTOR});
    chk("pc_load", {31'd0, pc_load}, {31'd0, m_mode == M_VECTOR || m_mode == M_RETURN});
    chk("pc_next", pc_next, m_mode == M_VECTOR ? VEC : (m_mode == M_RETURN ? m_epc : 32'd0));
    chk("exl", {31'd0, exl}, {31'd0, m_exl});
    chk("ovf_cnt", {24'd0, ovf_cnt}, m_cnt);
    chk("cp0_rdata", cp0_rdata, model_read(cp0_addr));
  endtask

  task automatic idle_in();
    ovf_chk = 0; ovf = 0; eret = 0; cp0_we = 0; ctrl_ack = 0;
    cp0_wdata = 0; pc_cur = 0;
  endtask

  // one clock: inputs already driven; model follows the edge, check mid-cycle
  task automatic tick();
    @(posedge gclk);
    model_step();
    @(negedge gclk);
    check_all();
    idle_in();
  endtask

  task automatic rd(input string tag, input logic [4:0] a, input logic [31:0] exp);
    cp0_addr = a;
    #1;
    chk(tag, cp0_rdata, exp);
  endtask

  initial begin
    int ack_cycles;
    idle_in();
    cp0_addr = 5'd14;
    rst_n = 0;
    model_reset();
    #12;
    check_all();
    rst_n = 1;
    @(negedge gclk);

    // overflow entry with ack held off three cycles
    ovf_chk = 1; ovf = 1; pc_cur = 32'h0040_0010; tick();
    ack_cycles = 0;
    for (int i = 0; i < 3; i++) begin
      if (exc_req) ack_cycles++;
      tick();
    end
    chk("req_cycles", ack_cycles, 3);
    ctrl_ack = 1; tick();
    chk("vec_pc", pc_next, 32'h8000_0180);
    tick();
    rd("epc_entry", 5'd14, 32'h0040_0010);
    rd("cause_entry", 5'd13, 32'h30);
    rd("status_entry", 5'd12, 32'h2);

    // no overflow: nothing changes
    ovf_chk = 1; ovf = 0; pc_cur = 32'hdead_beef; tick();
    rd("epc_noovf", 5'd14, 32'h0040_0010);

    // nested overflow keeps EPC; same-cycle eret is dropped
    ovf_chk = 1; ovf = 1; eret = 1; pc_cur = 32'h8000_0184; tick();
    ctrl_ack = 1; tick();
    tick();
    rd("epc_nested", 5'd14, 32'h0040_0010);

    // return
    eret = 1; tick();
    chk("ret_pc", pc_next, 32'h0040_0010);
    tick();
    chk("exl_after_ret", {31'd0, exl}, 32'd0);

    // mtc0 EPC then eret; Status write masking
    cp0_we = 1; cp0_addr = 5'd14; cp0_wdata = 32'h1234_5678; tick();
    eret = 1; tick();
    chk("ret_mtc0_pc", pc_next, 32'h1234_5678);
    tick();
    cp0_we = 1; cp0_addr = 5'd12; cp0_wdata = 32'hffff_ffff; tick();
    rd("status_mask", 5'd12, 32'h3);
    rd("unmapped", 5'd3, 32'h0);

    // reset mid-TRAP
    cp0_addr = 5'd14;
    ovf_chk = 1; ovf = 1; pc_cur = 32'h0000_4444; tick();
    rst_n = 0;
    #1;
    model_reset();
    chk("rst_req", {31'd0, exc_req}, 32'd0);
    chk("rst_kill", {31'd0, wb_kill}, 32'd0);
    chk("rst_load", {31'd0, pc_load}, 32'd0);
    @(negedge gclk);
    rst_n = 1;
    rd("rst_epc", 5'd14, 32'd0);
    tick();

    // 256 overflows saturate the counter
    for (int i = 0; i < 256; i++) begin
      ovf_chk = 1; ovf = 1; pc_cur = i; tick();
      ctrl_ack = 1; tick();
      tick();
    end
    chk("cnt_sat", {24'd0, ovf_cnt}, 32'd255);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      ovf_chk   = ($urandom_range(0, 9) < 3);
      ovf       = $urandom_range(0, 1);
      eret      = ($urandom_range(0, 9) < 2);
      ctrl_ack  = $urandom_range(0, 1);
      cp0_we    = ($urandom_range(0, 9) < 2);
      cp0_addr  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31))
                                              : 5'($urandom_range(12, 14));
      cp0_wdata = $urandom;
      pc_cur    = $urandom;
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
